dac_spi_mc: RTL and testbench
=============================

# dac_spi_mc

Multi-channel serial DAC write engine: the parametrised successor of the single-channel 16-bit DAC shifter. It accepts one sweep of up to N_CH channel words in a single handshake and serialises each enabled channel as an address-plus-data frame. It drives chip select, a divided serial clock, serial data and the LDAC latch strobe. It sits between the sample-generation logic and the external multi-channel DAC.

## Interface
- DATA_W, 16: data bits per channel word.
- ADDR_W, 2: channel-address bits prefixed to each frame. Must satisfy 2^ADDR_W >= N_CH.
- N_CH, 4: number of channels per sweep.
- DIV, 4: sclk period in clk cycles. Even, >= 2.
- CS_GAP, 2: minimum clk cycles cs stays high between frames. >= 1.
- LDAC_W, 2: ldac low pulse width in clk cycles. >= 1.
- LDAC_MODE, 0: 0 = pulse after every frame; 1 = one pulse after the last frame of a sweep.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  N_CH*DATA_W  channel words; channel c occupies bits [c*DATA_W +: DATA_W].
- ch_mask  in  N_CH  channel enable for the sweep; sampled together with din.
- din_vld  in  1  sweep request.
- rdy  out  1  engine idle; a sweep is accepted on any cycle where din_vld && rdy.
- busy  out  1  equals !rdy.
- cs  out  1  DAC chip select, active low.
- sclk  out  1  serial clock; idles low.
- sdi  out  1  serial data, MSB first.
- ldac  out  1  DAC latch strobe, active low.

## Operation
- Reset values: rdy=1, busy=0, cs=1, sclk=0, sdi=0, ldac=1. Assertion of rst forces these immediately, including mid-frame; the in-flight sweep is discarded.
- Acceptance: din and ch_mask are registered on the handshake cycle. din_vld while rdy=0 is ignored and does not alter the captured data.
- Frame: F = ADDR_W+DATA_W bits. The first ADDR_W bits are the channel index c, MSB first; the remaining DATA_W bits are the data word, MSB first.
- Channel order: ascending c, skipping channels with mask bit 0.
- FSM states:
  - IDLE: rdy=1. Handshake with mask != 0 goes to SHIFT for the lowest enabled channel. Handshake with mask = 0 goes to POST with no frame and no ldac.
  - SHIFT: cs=0; F bits are shifted. After the last bit, go to POST.
  - POST: cs=1 for P cycles. P = max(CS_GAP, LDAC_W+1) when this frame owns an ldac pulse, otherwise CS_GAP; P = 1 for the empty sweep. Then go to SHIFT if a further enabled channel remains, else IDLE.
- SPI mode 0: sdi changes while sclk is low; the DAC samples on sclk rising.
- ldac pulse:
  - LDAC_MODE=0: after every frame.
  - LDAC_MODE=1: only after the final frame of the sweep.
  - The pulse is never asserted while cs=0.

## Timing
Handshake at cycle T.
- T+1: cs=0, sdi=bit F-1, sclk=0, rdy=0.
- Bit k (k=0 is the first bit sent) is driven on sdi from T+1+k*DIV.
- sclk rises at T+1+k*DIV+DIV/2 and falls at T+1+(k+1)*DIV.
- Exactly F rising edges per frame.
- cs is low for exactly F*DIV cycles and returns high at R = T+1+F*DIV, coincident with the final sclk fall. sdi returns to 0 at R.
- ldac is low during cycles R+1 .. R+LDAC_W.
- The next frame's cs falls at R+P. If no frame remains, rdy=1 at R+P, so a new handshake is possible at R+P.
- Empty mask: rdy=0 at T+1, rdy=1 at T+2; cs, sclk and ldac stay idle.
- Defaults (F=18, DIV=4): 72 cycles cs low per frame, P=3 in LDAC_MODE=0.
- Counters: a divider counting 0..DIV-1 and a bit counter counting 0..F-1, both wrapping to 0 at frame end. The channel pointer counts 0..N_CH-1 with no wrap within a sweep.

## Test plan
- Defaults, mask=4'b0001, ch0=16'hA5C3 -> 18 sclk rises sample 00_1010010111000011. cs low 72 cycles. ldac low 2 cycles starting R+1. rdy=1 at R+3.
- mask=4'b1010, ch1=16'h0001, ch3=16'h8000 -> two frames, addresses 01 then 11, data as given. cs high exactly 3 cycles between frames. Two ldac pulses.
- LDAC_MODE=1, mask=4'b1111 -> four frames with 2-cycle cs gaps. Single ldac pulse after the fourth frame only.
- mask=0 -> rdy low exactly one cycle; no cs, sclk or ldac activity.
- din_vld pulsed with changed din during a frame -> ignored; transmitted bits unchanged. rst asserted at bit 7 -> cs=1, sclk=0, sdi=0, ldac=1, rdy=1 immediately. A fresh sweep after release is transmitted correctly.
- DATA_W=12, ADDR_W=1, N_CH=2, DIV=2 -> 13-bit frames, cs low 26 cycles, 13 sclk rises, bit-exact data.

Source files
------------

// File: rtl/dac_spi_mc.sv
// Multi-channel serial DAC write engine: one handshake captures a sweep of channel words,
// each enabled channel is sent as an {address, data} SPI mode-0 frame followed by an optional ldac strobe.
module dac_spi_mc #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 2,
  parameter int N_CH      = 4,
  parameter int DIV       = 4,
  parameter int CS_GAP    = 2,
  parameter int LDAC_W    = 2,
  parameter int LDAC_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   din,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic                     din_vld,
  output logic                     rdy,
  output logic                     busy,
  output logic                     cs,
  output logic                     sclk,
  output logic                     sdi,
  output logic                     ldac
);

  localparam int F     = ADDR_W + DATA_W;
  localparam int P_OWN = (CS_GAP > LDAC_W + 1) ? CS_GAP : LDAC_W + 1;
  localparam int PW    = $clog2(P_OWN + 1);
  localparam int DW    = $clog2(DIV);
  localparam int BW    = $clog2(F);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [DW-1:0] DIV_MID      = DW'(DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_END      = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_END      = BW'(F - 1);
  localparam logic [PW-1:0] POST_OWN_END = PW'(P_OWN - 1);
  localparam logic [PW-1:0] POST_GAP_END = PW'(CS_GAP - 1);
  localparam logic [PW-1:0] LDAC_CNT     = PW'(LDAC_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;

  logic [1:0]             state_reg;
  logic [N_CH*DATA_W-1:0] data_reg;
  logic [N_CH-1:0]        mask_left_reg;
  logic [F-1:0]           shift_reg;
  logic [DW-1:0]          div_cnt_reg;
  logic [BW-1:0]          bit_cnt_reg;
  logic [PW-1:0]          post_cnt_reg;
  logic [PW-1:0]          post_end_reg;
  logic                   ldac_own_reg;
  logic                   rdy_reg;
  logic                   cs_reg;
  logic                   sclk_reg;
  logic                   sdi_reg;
  logic                   ldac_reg;

  logic [N_CH*DATA_W-1:0] src_data;
  logic [N_CH-1:0]        src_mask;
  logic [N_CH-1:0]        nxt_mask;
  logic [CW-1:0]          nxt_ch;
  logic [F-1:0]           nxt_frame;
  logic                   post_done;
  logic                   frame_owns;
  logic                   load_frame;

  // The first frame is built straight from the handshake inputs; later frames from the captured sweep.
  always_comb begin
    src_data = (state_reg == S_IDLE) ? din : data_reg;
    src_mask = (state_reg == S_IDLE) ? ch_mask : mask_left_reg;
    nxt_ch   = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (src_mask[c]) nxt_ch = CW'(c);
    end
    nxt_mask   = src_mask & ~(N_CH'(1) << nxt_ch);
    nxt_frame  = {ADDR_W'(nxt_ch), src_data[nxt_ch*DATA_W +: DATA_W]};
    post_done  = (post_cnt_reg == post_end_reg);
    frame_owns = (LDAC_MODE == 0) || (mask_left_reg == '0);
    load_frame = (src_mask != '0) &&
                 (((state_reg == S_IDLE) && din_vld) || ((state_reg == S_POST) && post_done));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      data_reg      <= '0;
      mask_left_reg <= '0;
      shift_reg     <= '0;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      post_end_reg  <= '0;
      ldac_own_reg  <= 1'b0;
      rdy_reg       <= 1'b1;
      cs_reg        <= 1'b1;
      sclk_reg      <= 1'b0;
      sdi_reg       <= 1'b0;
      ldac_reg      <= 1'b1;
    end else begin
      if ((state_reg == S_IDLE) && din_vld) data_reg <= din;
      if (load_frame) begin
        state_reg     <= S_SHIFT;
        shift_reg     <= nxt_frame;
        mask_left_reg <= nxt_mask;
        div_cnt_reg   <= '0;
        bit_cnt_reg   <= '0;
        cs_reg        <= 1'b0;
        sdi_reg       <= nxt_frame[F-1];
        sclk_reg      <= 1'b0;
        ldac_reg      <= 1'b1;
        rdy_reg       <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            // Empty sweep: a single POST cycle with no frame and no strobe.
            if (din_vld) begin
              state_reg     <= S_POST;
              mask_left_reg <= '0;
              post_cnt_reg  <= '0;
              post_end_reg  <= '0;
              ldac_own_reg  <= 1'b0;
              rdy_reg       <= 1'b0;
            end
          end
          S_SHIFT: begin
            div_cnt_reg <= div_cnt_reg + DW'(1);
            if (div_cnt_reg == DIV_MID) sclk_reg <= 1'b1;
            if (div_cnt_reg == DIV_END) begin
              div_cnt_reg <= '0;
              sclk_reg    <= 1'b0;
              if (bit_cnt_reg == BIT_END) begin
                state_reg    <= S_POST;
                bit_cnt_reg  <= '0;
                cs_reg       <= 1'b1;
                sdi_reg      <= 1'b0;
                post_cnt_reg <= '0;
                post_end_reg <= frame_owns ? POST_OWN_END : POST_GAP_END;
                ldac_own_reg <= frame_owns;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + BW'(1);
                shift_reg   <= {shift_reg[F-2:0], 1'b0};
                sdi_reg     <= shift_reg[F-2];
              end
            end
          end
          S_POST: begin
            post_cnt_reg <= post_cnt_reg + PW'(1);
            ldac_reg     <= !(ldac_own_reg && (post_cnt_reg < LDAC_CNT));
            if (post_done) begin
              state_reg <= S_IDLE;
              rdy_reg   <= 1'b1;
              ldac_reg  <= 1'b1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign rdy  = rdy_reg;
  assign busy = !rdy_reg;
  assign cs   = cs_reg;
  assign sclk = sclk_reg;
  assign sdi  = sdi_reg;
  assign ldac = ldac_reg;

endmodule

// File: tb/tb_dac_spi_mc.sv
// Bench for dac_spi_mc: three configurations (default, sweep-end ldac, narrow 13-bit frames) checked
// cycle by cycle against a waveform model built from the frame/timing rules.
module tb_dac_spi_mc;

  localparam int GAP = 2;
  localparam int LW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] din0, din1;
  logic [23:0] din2;
  logic [3:0]  mask0, mask1;
  logic [1:0]  mask2;
  logic        vld0, vld1, vld2;
  logic        rdy0, busy0, cs0, sclk0, sdi0, ldac0;
  logic        rdy1, busy1, cs1, sclk1, sdi1, ldac1;
  logic        rdy2, busy2, cs2, sclk2, sdi2, ldac2;

  dac_spi_mc u0 (
    .clk(clk), .rst(rst), .din(din0), .ch_mask(mask0), .din_vld(vld0),
    .rdy(rdy0), .busy(busy0), .cs(cs0), .sclk(sclk0), .sdi(sdi0), .ldac(ldac0));

  dac_spi_mc #(.LDAC_MODE(1)) u1 (
    .clk(clk), .rst(rst), .din(din1), .ch_mask(mask1), .din_vld(vld1),
    .rdy(rdy1), .busy(busy1), .cs(cs1), .sclk(sclk1), .sdi(sdi1), .ldac(ldac1));

  dac_spi_mc #(.DATA_W(12), .ADDR_W(1), .N_CH(2), .DIV(2)) u2 (
    .clk(clk), .rst(rst), .din(din2), .ch_mask(mask2), .din_vld(vld2),
    .rdy(rdy2), .busy(busy2), .cs(cs2), .sclk(sclk2), .sdi(sdi2), .ldac(ldac2));

  // Observation vector: {rdy, cs, sclk, sdi, ldac, busy}
  logic [5:0] o0, o1, o2, obs;
  assign o0 = {rdy0, cs0, sclk0, sdi0, ldac0, busy0};
  assign o1 = {rdy1, cs1, sclk1, sdi1, ldac1, busy1};
  assign o2 = {rdy2, cs2, sclk2, sdi2, ldac2, busy2};

  int sel_cur = 0;
  always_comb begin
    obs = o2;
    if (sel_cur == 0) obs = o0;
    else if (sel_cur == 1) obs = o1;
  end

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  localparam logic [5:0] IDLE_V = 6'b110010;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [63:0] din, input logic [3:0] mask, input logic v);
    case (sel)
      0: begin din0 = din; mask0 = mask; vld0 = v; end
      1: begin din1 = din; mask1 = mask; vld1 = v; end
      default: begin din2 = din[23:0]; mask2 = mask[1:0]; vld2 = v; end
    endcase
  endtask

  // Expected per-cycle outputs from T+1 up to and including the first idle (rdy=1) cycle.
  task automatic build_trace(input int sel, input logic [63:0] din, input logic [3:0] mask);
    int dw, aw, nch, dv, mode, f, last, p;
    logic [63:0] frame;
    logic [3:0] m;
    bit own;
    dw   = (sel == 2) ? 12 : 16;
    aw   = (sel == 2) ? 1 : 2;
    nch  = (sel == 2) ? 2 : 4;
    dv   = (sel == 2) ? 2 : 4;
    mode = (sel == 1) ? 1 : 0;
    f    = aw + dw;
    m    = (nch == 2) ? {2'b00, mask[1:0]} : mask;
    exp_q.delete();
    last = -1;
    for (int c = 0; c < nch; c++) if (m[c]) last = c;
    if (last < 0) exp_q.push_back(6'b010011);
    for (int c = 0; c < nch; c++) begin
      if (m[c]) begin
        frame = (64'(c) << dw) | ((din >> (c * dw)) & ((64'd1 << dw) - 64'd1));
        for (int k = 0; k < f; k++)
          for (int d = 0; d < dv; d++)
            exp_q.push_back({1'b0, 1'b0, (d >= dv / 2), frame[f-1-k], 1'b1, 1'b1});
        own = (mode == 0) || (c == last);
        p   = own ? ((GAP > LW + 1) ? GAP : LW + 1) : GAP;
        for (int j = 0; j < p; j++)
          exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, !(own && j >= 1 && j <= LW), 1'b1});
      end
    end
    exp_q.push_back(IDLE_V);
  endtask

  task automatic run_sweep(input int sel, input logic [63:0] din, input logic [3:0] mask,
                           input int inject_at, input int abort_at,
                           output int rises, output int cs_low, output int ldac_falls, output int busy_cyc);
    logic [5:0] prev;
    int inj;
    build_trace(sel, din, mask);
    sel_cur = sel;
    rises = 0; cs_low = 0; ldac_falls = 0; busy_cyc = 0;
    inj = (inject_at + 1 < exp_q.size()) ? inject_at : -10;
    @(negedge clk);
    drive(sel, din, mask, 1'b1);
    prev = obs;
    @(negedge clk);
    drive(sel, din, mask, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL trace sel=%0d cyc=%0d got=%b expected=%b", sel, i, obs, exp_q[i]);
      end
      if (obs[3] && !prev[3]) rises++;
      if (!obs[4]) cs_low++;
      if (prev[1] && !obs[1]) ldac_falls++;
      if (!obs[5]) busy_cyc++;
      prev = obs;
      if (i == inj) drive(sel, ~din, 4'hF, 1'b1);
      if (i == inj + 1) drive(sel, din, mask, 1'b0);
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_async", obs, IDLE_V);
        @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    drive(sel, din, mask, 1'b0);
  endtask

  typedef struct {
    int          sel;
    logic [63:0] din;
    logic [3:0]  mask;
    int          inject;
    int          rises;
    int          cs_low;
    int          ldac;
    int          busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int r, c, l, b;
    tbl[0] = '{0, 64'h0000_0000_0000_A5C3, 4'b0001, -1, 18, 72, 1, 75};
    tbl[1] = '{0, 64'h8000_0000_0001_0000, 4'b1010, -1, 36, 144, 2, 150};
    tbl[2] = '{1, 64'h1111_2222_3333_4444, 4'b1111, -1, 72, 288, 1, 297};
    tbl[3] = '{0, 64'hDEAD_BEEF_0BAD_F00D, 4'b0000, -1, 0, 0, 0, 1};
    tbl[4] = '{2, 64'h0000_0000_00AB_C123, 4'b0011, -1, 26, 52, 2, 58};
    tbl[5] = '{0, 64'hFEDC_BA98_7654_3210, 4'b1111, 100, 72, 288, 4, 300};
    tbl[6] = '{2, 64'h0000_0000_005A_5FFF, 4'b0010, 5, 13, 26, 1, 29};
    tbl[7] = '{1, 64'h0000_C0DE_0000_0000, 4'b0100, -1, 18, 72, 1, 75};

    rst = 1'b1;
    drive(0, 64'd0, 4'd0, 1'b0);
    drive(1, 64'd0, 4'd0, 1'b0);
    drive(2, 64'd0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_u0", o0, IDLE_V);
    check("reset_u1", o1, IDLE_V);
    check("reset_u2", o2, IDLE_V);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_u0", o0, IDLE_V);

    for (int i = 0; i < 8; i++) begin
      run_sweep(tbl[i].sel, tbl[i].din, tbl[i].mask, tbl[i].inject, -1, r, c, l, b);
      check($sformatf("vec%0d_rises", i), r, tbl[i].rises);
      check($sformatf("vec%0d_cs_low", i), c, tbl[i].cs_low);
      check($sformatf("vec%0d_ldac", i), l, tbl[i].ldac);
      check($sformatf("vec%0d_busy", i), b, tbl[i].busy);
    end

    // Abort mid-frame at bit 7 (sclk high, sdi=1), then a fresh sweep must go out intact.
    run_sweep(0, 64'h0000_0000_0000_A5C3, 4'b0001, -1, 30, r, c, l, b);
    check("abort_cs_low", c, 31);
    run_sweep(0, 64'h1234_5678_9ABC_DEF0, 4'b0110, -1, -1, r, c, l, b);
    check("after_abort_rises", r, 36);
    check("after_abort_ldac", l, 2);

    for (int i = 0; i < 24; i++) begin
      int sel, inj;
      logic [63:0] d;
      logic [3:0] m;
      sel = int'($urandom_range(0, 2));
      d   = {$urandom, $urandom};
      m   = 4'($urandom_range(0, 15));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
      run_sweep(sel, d, m, inj, -1, r, c, l, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
